// File: rtl/wm_pkg.sv
// Shared washing-machine encodings and default timing values,
// used by the sequencer and the dry timer block.
package wm_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FILL   = 4'd1;
  localparam logic [3:0] S_WASH   = 4'd2;
  localparam logic [3:0] S_DRAIN1 = 4'd3;
  localparam logic [3:0] S_RFILL  = 4'd4;
  localparam logic [3:0] S_RINSE  = 4'd5;
  localparam logic [3:0] S_DRAIN2 = 4'd6;
  localparam logic [3:0] S_SPIN   = 4'd7;
  localparam logic [3:0] S_DRY    = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
  localparam logic [3:0] S_ERROR  = 4'd15;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_QUICK  = 2'b01;
  localparam logic [1:0] MODE_HEAVY  = 2'b10;

  localparam int CW_DEF            = 11;
  localparam int WASH_TICKS_DEF    = 300;
  localparam int RINSE_TICKS_DEF   = 150;
  localparam int SPIN_TICKS_DEF    = 120;
  localparam int FILL_TIMEOUT_DEF  = 200;
  localparam int DRAIN_TIMEOUT_DEF = 200;
  localparam int DRY_TIMEOUT_DEF   = 1023;
  localparam int REV_PERIOD_DEF    = 20;

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// Sensor/actuator bundle between the panel/plant side (master) and the sequencer (slave).
interface wash_cycle_sequencer_if;
  logic       StartBtn;
  logic [1:0] Mode;
  logic       Pause;
  logic       DoorClosed;
  logic       WaterFull;
  logic       WaterEmpty;
  logic       DryDone;
  logic       FillValve;
  logic       DrainPump;
  logic       MotorEn;
  logic       MotorRev;
  logic       DryStart;
  logic       DoorLock;
  logic       Done;
  logic       Fault;
  logic [3:0] Phase;

  modport master (
    output StartBtn, Mode, Pause, DoorClosed, WaterFull, WaterEmpty, DryDone,
    input  FillValve, DrainPump, MotorEn, MotorRev, DryStart, DoorLock, Done, Fault, Phase
  );

  modport slave (
    input  StartBtn, Mode, Pause, DoorClosed, WaterFull, WaterEmpty, DryDone,
    output FillValve, DrainPump, MotorEn, MotorRev, DryStart, DoorLock, Done, Fault, Phase
  );
endinterface

// File: rtl/phase_timer.sv
// Clearable CW-bit up-counter; expire is high while count == limit-1.
module phase_timer #(
  parameter int CW = 11
) (
  input  logic          CLK,
  input  logic          nReset,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          expire
);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (!nReset)  count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + CW'(1);
  end

  assign expire = (count == limit - CW'(1));

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Wash programme FSM: fill/wash/drain/rinse/spin/dry sequencing with
// door interlock, sensor timeouts and a sticky fault state.
module wash_cycle_sequencer
  import wm_pkg::*;
#(
  parameter int CW            = CW_DEF,
  parameter int WASH_TICKS    = WASH_TICKS_DEF,
  parameter int RINSE_TICKS   = RINSE_TICKS_DEF,
  parameter int SPIN_TICKS    = SPIN_TICKS_DEF,
  parameter int FILL_TIMEOUT  = FILL_TIMEOUT_DEF,
  parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
  parameter int DRY_TIMEOUT   = DRY_TIMEOUT_DEF,
  parameter int REV_PERIOD    = REV_PERIOD_DEF
) (
  input  logic                   CLK,
  input  logic                   nReset,
  wash_cycle_sequencer_if.slave  bus
);

  logic [3:0]    state, nxt;
  logic          start_q, start_edge;
  logic          active, run, leave;
  logic          rev_phase, rev_run, rev_clr, motor_rev;
  logic [CW-1:0] wash_lim, ph_lim;
  logic          ph_exp, rev_exp;

  assign start_edge = bus.StartBtn & ~start_q;
  assign active     = (state >= S_FILL) && (state <= S_DRY);
  assign run        = active & ~bus.Pause;
  assign leave      = (nxt != state);
  assign rev_phase  = (state == S_WASH) || (state == S_RINSE);
  assign rev_run    = rev_phase & ~bus.Pause;
  assign rev_clr    = leave | ~rev_phase | (rev_run & rev_exp);

  // Heavy mode doubles at CW bits; CW must leave headroom for 2*WASH_TICKS.
  always_comb begin
    case (bus.Mode)
      MODE_QUICK: wash_lim = CW'(WASH_TICKS) >> 1;
      MODE_HEAVY: wash_lim = CW'(WASH_TICKS) << 1;
      default:    wash_lim = CW'(WASH_TICKS);
    endcase
  end

  always_comb begin
    case (state)
      S_FILL, S_RFILL:   ph_lim = CW'(FILL_TIMEOUT);
      S_DRAIN1, S_DRAIN2: ph_lim = CW'(DRAIN_TIMEOUT);
      S_WASH:            ph_lim = wash_lim;
      S_RINSE:           ph_lim = CW'(RINSE_TICKS);
      S_SPIN:            ph_lim = CW'(SPIN_TICKS);
      S_DRY:             ph_lim = CW'(DRY_TIMEOUT);
      default:           ph_lim = '1;
    endcase
  end

  phase_timer #(.CW(CW)) u_phase (
    .CLK(CLK), .nReset(nReset), .clr(leave | ~active), .en(run),
    .limit(ph_lim), .expire(ph_exp)
  );

  phase_timer #(.CW(CW)) u_rev (
    .CLK(CLK), .nReset(nReset), .clr(rev_clr), .en(rev_run),
    .limit(CW'(REV_PERIOD)), .expire(rev_exp)
  );

  // Door-open beats pause; pause beats every sensor and expiry event.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_edge && bus.DoorClosed) nxt = S_FILL;
      S_ERROR:        nxt = S_ERROR;
      default: begin
        if (!bus.DoorClosed) nxt = S_ERROR;
        else if (!bus.Pause) begin
          case (state)
            S_FILL:   if (bus.WaterFull)  nxt = S_WASH;   else if (ph_exp) nxt = S_ERROR;
            S_RFILL:  if (bus.WaterFull)  nxt = S_RINSE;  else if (ph_exp) nxt = S_ERROR;
            S_DRAIN1: if (bus.WaterEmpty) nxt = S_RFILL;  else if (ph_exp) nxt = S_ERROR;
            S_DRAIN2: if (bus.WaterEmpty) nxt = S_SPIN;   else if (ph_exp) nxt = S_ERROR;
            S_WASH:   if (ph_exp) nxt = S_DRAIN1;
            S_RINSE:  if (ph_exp) nxt = S_DRAIN2;
            S_SPIN:   if (ph_exp) nxt = S_DRY;
            S_DRY:    if (bus.DryDone) nxt = S_DONE; else if (ph_exp) nxt = S_ERROR;
            default:  nxt = S_ERROR;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nReset) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      motor_rev <= 1'b0;
    end else begin
      state   <= nxt;
      start_q <= bus.StartBtn;
      if (leave)                  motor_rev <= 1'b0;
      else if (rev_run & rev_exp) motor_rev <= ~motor_rev;
    end
  end

  assign bus.FillValve = ((state == S_FILL) || (state == S_RFILL)) & ~bus.Pause;
  assign bus.DrainPump = ((state == S_DRAIN1) || (state == S_DRAIN2) || (state == S_SPIN)) & ~bus.Pause;
  assign bus.MotorEn   = ((state == S_WASH) || (state == S_RINSE) || (state == S_SPIN)) & ~bus.Pause;
  assign bus.MotorRev  = motor_rev;
  assign bus.DryStart  = (state == S_DRY);
  assign bus.DoorLock  = active;
  assign bus.Done      = (state == S_DONE);
  assign bus.Fault     = (state == S_ERROR);
  assign bus.Phase     = state;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer with short phase timings and a dry-timer stub.
module tb_wash_cycle_sequencer;

  logic CLK = 1'b0;
  logic nReset = 1'b0;
  always #5 CLK = ~CLK;

  wash_cycle_sequencer_if bus();

  int errors = 0;
  int checks = 0;

  // Dry stub: one-cycle DryDone pulse 5 cycles after DryStart rises.
  logic man_dry = 1'b0;
  int   dry_cnt = 0;
  logic stub_done;
  assign stub_done   = bus.DryStart && (dry_cnt == 5);
  assign bus.DryDone = stub_done | man_dry;
  always @(posedge CLK) dry_cnt <= bus.DryStart ? dry_cnt + 1 : 0;

  logic [7:0] outs;
  assign outs = {bus.FillValve, bus.DrainPump, bus.MotorEn, bus.MotorRev,
                 bus.DryStart, bus.DoorLock, bus.Done, bus.Fault};

  wash_cycle_sequencer #(
    .CW(11), .WASH_TICKS(8), .RINSE_TICKS(4), .SPIN_TICKS(4),
    .FILL_TIMEOUT(6), .DRAIN_TIMEOUT(6), .DRY_TIMEOUT(20), .REV_PERIOD(2)
  ) dut (
    .CLK(CLK),
    .nReset(nReset),
    .bus(bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
  endtask

  task automatic start_press();
    bus.StartBtn = 1'b1;
    tick();
    bus.StartBtn = 1'b0;
  endtask

  // Called on the first observed cycle of a fill phase; sensor rises 2 cycles in.
  task automatic fill_step();
    tick(); tick();
    bus.WaterFull = 1'b1;
    tick();
    bus.WaterFull = 1'b0;
  endtask

  task automatic drain_step();
    tick(); tick();
    bus.WaterEmpty = 1'b1;
    tick();
    bus.WaterEmpty = 1'b0;
  endtask

  // Number of consecutive observed cycles spent in phase p (bounded).
  task automatic measure(input logic [3:0] p, output int n);
    n = 0;
    while (bus.Phase == p && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    tick(); tick();
    checks++; if (bus.Phase !== 4'd0) begin errors++; $display("FAIL reset_phase got=%0d want=0", bus.Phase); end
    checks++; if (outs !== 8'h00) begin errors++; $display("FAIL reset_outs got=%b want=00000000", outs); end
    nReset = 1'b1;
    tick();
    checks++; if (bus.Phase !== 4'd0) begin errors++; $display("FAIL reset_idle_hold got=%0d want=0", bus.Phase); end
  endtask

  task automatic test_normal();
    int n;
    logic exp_rev;
    do_reset();
    start_press();
    checks++; if (bus.Phase !== 4'd1) begin errors++; $display("FAIL normal_fill got=%0d want=1", bus.Phase); end
    checks++; if (outs !== 8'b1000_0100) begin errors++; $display("FAIL normal_fill_outs got=%b want=10000100", outs); end
    fill_step();
    checks++; if (bus.Phase !== 4'd2) begin errors++; $display("FAIL normal_wash got=%0d want=2", bus.Phase); end
    n = 0;
    while (bus.Phase == 4'd2 && n < 100) begin
      exp_rev = ((n / 2) % 2) == 1;
      checks++; if (bus.MotorRev !== exp_rev || bus.MotorEn !== 1'b1) begin
        errors++; $display("FAIL normal_rev cycle=%0d rev=%b en=%b want rev=%b en=1", n, bus.MotorRev, bus.MotorEn, exp_rev);
      end
      n++;
      tick();
    end
    checks++; if (n != 8) begin errors++; $display("FAIL normal_wash_len got=%0d want=8", n); end
    checks++; if (bus.Phase !== 4'd3 || outs !== 8'b0100_0100) begin errors++; $display("FAIL normal_drain1 phase=%0d outs=%b want 3/01000100", bus.Phase, outs); end
    drain_step();
    checks++; if (bus.Phase !== 4'd4) begin errors++; $display("FAIL normal_rfill got=%0d want=4", bus.Phase); end
    fill_step();
    checks++; if (bus.Phase !== 4'd5) begin errors++; $display("FAIL normal_rinse got=%0d want=5", bus.Phase); end
    measure(4'd5, n);
    checks++; if (n != 4) begin errors++; $display("FAIL normal_rinse_len got=%0d want=4", n); end
    checks++; if (bus.Phase !== 4'd6) begin errors++; $display("FAIL normal_drain2 got=%0d want=6", bus.Phase); end
    drain_step();
    checks++; if (bus.Phase !== 4'd7 || outs !== 8'b0110_0100) begin errors++; $display("FAIL normal_spin phase=%0d outs=%b want 7/01100100", bus.Phase, outs); end
    measure(4'd7, n);
    checks++; if (n != 4) begin errors++; $display("FAIL normal_spin_len got=%0d want=4", n); end
    checks++; if (bus.Phase !== 4'd8 || outs !== 8'b0000_1100) begin errors++; $display("FAIL normal_dry phase=%0d outs=%b want 8/00001100", bus.Phase, outs); end
    measure(4'd8, n);
    checks++; if (n != 6) begin errors++; $display("FAIL normal_dry_len got=%0d want=6", n); end
    checks++; if (bus.Phase !== 4'd9 || outs !== 8'b0000_0010) begin errors++; $display("FAIL normal_done phase=%0d outs=%b want 9/00000010", bus.Phase, outs); end
  endtask

  task automatic test_mode_sweep();
    int n;
    bus.Mode = 2'b01;
    start_press();
    checks++; if (bus.Phase !== 4'd1 || bus.Done !== 1'b0) begin errors++; $display("FAIL mode_restart phase=%0d done=%b want 1/0", bus.Phase, bus.Done); end
    fill_step();
    measure(4'd2, n);
    checks++; if (n != 4) begin errors++; $display("FAIL mode_quick_len got=%0d want=4", n); end
    do_reset();
    bus.Mode = 2'b10;
    start_press();
    fill_step();
    measure(4'd2, n);
    checks++; if (n != 16) begin errors++; $display("FAIL mode_heavy_len got=%0d want=16", n); end
    checks++; if (bus.Phase !== 4'd3) begin errors++; $display("FAIL mode_heavy_exit got=%0d want=3", bus.Phase); end
    bus.Mode = 2'b00;
    do_reset();
  endtask

  task automatic test_fill_timeout();
    int n;
    do_reset();
    start_press();
    measure(4'd1, n);
    checks++; if (n != 6) begin errors++; $display("FAIL timeout_fill_len got=%0d want=6", n); end
    checks++; if (bus.Phase !== 4'd15 || outs !== 8'b0000_0001) begin errors++; $display("FAIL timeout_error phase=%0d outs=%b want 15/00000001", bus.Phase, outs); end
    start_press();
    tick();
    checks++; if (bus.Phase !== 4'd15) begin errors++; $display("FAIL timeout_sticky got=%0d want=15", bus.Phase); end
    do_reset();
    checks++; if (bus.Phase !== 4'd0 || outs !== 8'h00) begin errors++; $display("FAIL timeout_reset phase=%0d outs=%b want 0/00000000", bus.Phase, outs); end
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    start_press();
    fill_step();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus.Phase !== 4'd2) begin errors++; $display("FAIL pause_pre got=%0d want=2", bus.Phase); end
    bus.Pause = 1'b1;
    #1;
    checks++; if (bus.MotorEn !== 1'b0 || bus.DoorLock !== 1'b1) begin errors++; $display("FAIL pause_gate en=%b lock=%b want 0/1", bus.MotorEn, bus.DoorLock); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.Phase !== 4'd2 || bus.MotorEn !== 1'b0 || bus.MotorRev !== 1'b0) begin
        errors++; $display("FAIL pause_hold cycle=%0d phase=%0d en=%b rev=%b want 2/0/0", i, bus.Phase, bus.MotorEn, bus.MotorRev);
      end
    end
    bus.Pause = 1'b0;
    measure(4'd2, n);
    checks++; if (n != 3) begin errors++; $display("FAIL pause_resume_len got=%0d want=3", n); end
    checks++; if (bus.Phase !== 4'd3) begin errors++; $display("FAIL pause_exit got=%0d want=3", bus.Phase); end
    do_reset();
  endtask

  task automatic test_door_fault();
    int n;
    do_reset();
    start_press();
    fill_step();
    measure(4'd2, n);
    drain_step();
    fill_step();
    checks++; if (bus.Phase !== 4'd5) begin errors++; $display("FAIL door_rinse got=%0d want=5", bus.Phase); end
    tick();
    bus.Pause = 1'b1;
    bus.DoorClosed = 1'b0;
    tick();
    checks++; if (bus.Phase !== 4'd15 || bus.Fault !== 1'b1) begin errors++; $display("FAIL door_error phase=%0d fault=%b want 15/1", bus.Phase, bus.Fault); end
    bus.Pause = 1'b0;
    do_reset();
    start_press();
    tick();
    checks++; if (bus.Phase !== 4'd0 || bus.DoorLock !== 1'b0) begin errors++; $display("FAIL door_open_start phase=%0d lock=%b want 0/0", bus.Phase, bus.DoorLock); end
    bus.DoorClosed = 1'b1;
    tick();
    checks++; if (bus.Phase !== 4'd0) begin errors++; $display("FAIL door_close_nostart got=%0d want=0", bus.Phase); end
  endtask

  task automatic test_reset_dry();
    int n;
    do_reset();
    start_press();
    fill_step();
    measure(4'd2, n);
    drain_step();
    fill_step();
    measure(4'd5, n);
    drain_step();
    measure(4'd7, n);
    checks++; if (bus.Phase !== 4'd8 || outs !== 8'b0000_1100) begin errors++; $display("FAIL rdry_in_dry phase=%0d outs=%b want 8/00001100", bus.Phase, outs); end
    tick(); tick();
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    checks++; if (bus.Phase !== 4'd0 || outs !== 8'h00) begin errors++; $display("FAIL rdry_reset phase=%0d outs=%b want 0/00000000", bus.Phase, outs); end
    man_dry = 1'b1;
    tick();
    man_dry = 1'b0;
    tick();
    checks++; if (bus.Phase !== 4'd0 || outs !== 8'h00) begin errors++; $display("FAIL rdry_ignore phase=%0d outs=%b want 0/00000000", bus.Phase, outs); end
  endtask

  initial begin
    bus.StartBtn   = 1'b0;
    bus.Mode       = 2'b00;
    bus.Pause      = 1'b0;
    bus.DoorClosed = 1'b1;
    bus.WaterFull  = 1'b0;
    bus.WaterEmpty = 1'b0;
    test_reset();
    test_normal();
    test_mode_sweep();
    test_fill_timeout();
    test_pause();
    test_door_fault();
    test_reset_dry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
